// File: rtl/parallel_to_serial_tx.sv
// Serial bit-stream transmitter: takes WIDTH-bit words over valid/ready and shifts
// them out one bit per bit_en strobe, with a one-word hold buffer for gapless frames.
module parallel_to_serial_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             bit_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             frame_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_FIRST = '0;
    localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shifter_q, shifter_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;

    logic serial_out_q;
    logic serial_valid_q;
    logic frame_start_q;
    logic frame_last_q;
    logic busy_q;

    logic xfer;

    // The bit presented on the line is always the one at the output end of the shifter.
    function automatic logic out_bit(input logic [WIDTH-1:0] s);
        return MSB_FIRST ? s[WIDTH-1] : s[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] s);
        return MSB_FIRST ? {s[WIDTH-2:0], 1'b0} : {1'b0, s[WIDTH-1:1]};
    endfunction

    assign in_ready = !hold_full_q && !reset;
    assign xfer     = in_valid && in_ready;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        shifter_d   = shifter_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    shifter_d = in_data;
                    cnt_d     = CNT_FIRST;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                if (bit_en && (cnt_q == CNT_LAST)) begin
                    // Last bit consumed: reload from hold first, else bypass, else stop.
                    if (hold_full_q) begin
                        shifter_d   = hold_q;
                        cnt_d       = CNT_FIRST;
                        hold_full_d = 1'b0;
                    end else if (xfer) begin
                        shifter_d = in_data;
                        cnt_d     = CNT_FIRST;
                    end else begin
                        shifter_d = '0;
                        cnt_d     = CNT_FIRST;
                        state_d   = IDLE;
                    end
                end else begin
                    if (bit_en) begin
                        shifter_d = shift_once(shifter_q);
                        cnt_d     = cnt_q + CW'(1);
                    end
                    if (xfer) begin
                        hold_d      = in_data;
                        hold_full_d = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            shifter_q      <= '0;
            cnt_q          <= '0;
            hold_q         <= '0;
            hold_full_q    <= 1'b0;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
            frame_start_q  <= 1'b0;
            frame_last_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            shifter_q   <= shifter_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;

            // Outputs are registered from next-state so they line up with the new state.
            serial_valid_q <= (state_d == SHIFT);
            serial_out_q   <= (state_d == SHIFT) && out_bit(shifter_d);
            frame_start_q  <= (state_d == SHIFT) && (cnt_d == CNT_FIRST);
            frame_last_q   <= (state_d == SHIFT) && (cnt_d == CNT_LAST);
            busy_q         <= (state_d == SHIFT) || hold_full_d;
        end
    end

    assign serial_out   = serial_out_q;
    assign serial_valid = serial_valid_q;
    assign frame_start  = frame_start_q;
    assign frame_last   = frame_last_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_parallel_to_serial_tx.sv
// Self-checking bench for parallel_to_serial_tx: directed and random steps compared
// against a word-queue model of the transmitted bit stream.
`timescale 1ns/1ps
module tb_parallel_to_serial_tx;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // 4-bit MSB-first instance
    logic [3:0] in_data4 = '0;
    logic       in_valid4 = 1'b0, bit_en4 = 1'b0;
    logic       in_ready4, ser4, sval4, fst4, flast4, busy4;
    // 8-bit LSB-first instance
    logic [7:0] in_data8 = '0;
    logic       in_valid8 = 1'b0, bit_en8 = 1'b0;
    logic       in_ready8, ser8, sval8, fst8, flast8, busy8;

    parallel_to_serial_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .in_data(in_data4), .in_valid(in_valid4),
        .in_ready(in_ready4), .bit_en(bit_en4), .serial_out(ser4),
        .serial_valid(sval4), .frame_start(fst4), .frame_last(flast4), .busy(busy4)
    );

    parallel_to_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
        .clk(clk), .reset(reset), .in_data(in_data8), .in_valid(in_valid8),
        .in_ready(in_ready8), .bit_en(bit_en8), .serial_out(ser8),
        .serial_valid(sval8), .frame_start(fst8), .frame_last(flast8), .busy(busy8)
    );

    bit   sel8 = 1'b0;
    logic o_ready, o_ser, o_val, o_fst, o_last, o_busy;
    assign o_ready = sel8 ? in_ready8 : in_ready4;
    assign o_ser   = sel8 ? ser8      : ser4;
    assign o_val   = sel8 ? sval8     : sval4;
    assign o_fst   = sel8 ? fst8      : fst4;
    assign o_last  = sel8 ? flast8    : flast4;
    assign o_busy  = sel8 ? busy8     : busy4;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the word on the line, how many of its bits are gone, and a
    // queue of accepted-but-not-started words.
    int         mw = 4;
    bit         mmsb = 1'b1;
    bit         act = 1'b0;
    logic [7:0] cur = '0;
    int         idx = 0;
    logic [7:0] pend[$];

    bit   cap[$];
    logic [3:0] rx = '0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] packed_cap();
        logic [15:0] p = '0;
        foreach (cap[i]) p = {p[14:0], cap[i]};
        return p;
    endfunction

    task automatic model_clear();
        act = 1'b0;
        cur = '0;
        idx = 0;
        pend.delete();
    endtask

    task automatic check_outputs();
        int   pos;
        logic eser;
        pos  = mmsb ? (mw - 1 - idx) : idx;
        eser = act ? cur[pos] : 1'b0;
        check("serial_valid", 16'(o_val), 16'(act));
        check("serial_out", 16'(o_ser), 16'(eser));
        check("frame_start", 16'(o_fst), 16'(act && idx == 0));
        check("frame_last", 16'(o_last), 16'(act && idx == mw - 1));
        check("busy", 16'(o_busy), 16'(act || pend.size() > 0));
    endtask

    task automatic model_edge(input bit v, input logic [7:0] d, input bit en);
        bit xfer;
        xfer = v && (pend.size() == 0);
        if (!act) begin
            if (xfer) begin
                cur = d; idx = 0; act = 1'b1;
            end
        end else if (en && idx == mw - 1) begin
            if (pend.size() > 0) begin
                cur = pend.pop_front(); idx = 0;
            end else if (xfer) begin
                cur = d; idx = 0;
            end else begin
                act = 1'b0; idx = 0;
            end
        end else begin
            if (en) idx++;
            if (xfer) pend.push_back(d);
        end
    endtask

    // One clock: check state at negedge, drive inputs, advance model, wait for posedge.
    task automatic step(input bit v, input logic [7:0] d, input bit en);
        @(negedge clk);
        check_outputs();
        if (sel8) begin
            in_valid8 = v; in_data8 = d; bit_en8 = en;
            in_valid4 = 1'b0; bit_en4 = 1'b0;
        end else begin
            in_valid4 = v; in_data4 = d[3:0]; bit_en4 = en;
            in_valid8 = 1'b0; bit_en8 = 1'b0;
        end
        check("in_ready", 16'(o_ready), 16'(pend.size() == 0));
        if (o_val && en) begin
            cap.push_back(o_ser);
            rx = {rx[2:0], o_ser};
        end
        model_edge(v, sel8 ? d : {4'h0, d[3:0]}, en);
        @(posedge clk);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        in_valid4 = 1'b0; bit_en4 = 1'b0; in_valid8 = 1'b0; bit_en8 = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_serial_out", 16'(o_ser), 16'h0);
        check("rst_serial_valid", 16'(o_val), 16'h0);
        check("rst_frame_start", 16'(o_fst), 16'h0);
        check("rst_frame_last", 16'(o_last), 16'h0);
        check("rst_busy", 16'(o_busy), 16'h0);
        check("rst_in_ready", 16'(o_ready), 16'h0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // Test 1: single word 1011, bit_en continuous
        do_reset();
        cap.delete();
        step(1'b1, 8'hB, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h0, 1'b1);
        check("t1_len", 16'(cap.size()), 16'd4);
        check("t1_bits", packed_cap(), 16'h000B);

        // Test 2: back-to-back A then 5 with in_valid held
        cap.delete();
        step(1'b1, 8'hA, 1'b1);
        step(1'b1, 8'h5, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h0, 1'b1);
        check("t2_len", 16'(cap.size()), 16'd8);
        check("t2_bits", packed_cap(), 16'h00A5);

        // Test 3: bit_en every third cycle, second word offered mid-frame
        cap.delete();
        step(1'b1, 8'hC, 1'b0);
        for (int i = 0; i < 30; i++)
            step(i == 1, 8'h9, (i % 3) == 2);
        check("t3_len", 16'(cap.size()), 16'd8);
        check("t3_bits", packed_cap(), 16'h00C9);

        // Test 4: reset after two bits of F, then 3 sent cleanly
        step(1'b1, 8'hF, 1'b1);
        step(1'b0, 8'h0, 1'b1);
        step(1'b0, 8'h0, 1'b1);
        do_reset();
        cap.delete();
        step(1'b1, 8'h3, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h0, 1'b1);
        check("t4_len", 16'(cap.size()), 16'd4);
        check("t4_bits", packed_cap(), 16'h0003);

        // Test 5: loopback into a 4-bit MSB-first receiver
        rx = '0;
        step(1'b1, 8'hD, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h0, 1'b1);
        check("t5_rx", 16'(rx), 16'h000D);
        for (int i = 0; i < 2; i++) step(1'b0, 8'h0, 1'b1);

        // Random traffic on the 4-bit instance
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
        for (int i = 0; i < 12; i++) step(1'b0, 8'h0, 1'b1);

        // Test 6: 8-bit LSB-first instance
        sel8 = 1'b1; mw = 8; mmsb = 1'b0;
        do_reset();
        cap.delete();
        step(1'b1, 8'h81, 1'b1);
        step(1'b1, 8'h02, 1'b1);
        for (int i = 0; i < 18; i++) step(1'b0, 8'h0, 1'b1);
        check("t6_len", 16'(cap.size()), 16'd16);
        check("t6_bits", packed_cap(), 16'h8140);

        // Random traffic on the 8-bit instance
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
        for (int i = 0; i < 20; i++) step(1'b0, 8'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
